// File: rtl/tl_pkg.sv
// TileLink-UL opcodes and the registered D-channel response bundle
// shared by the SRAM manager and its array.
package tl_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // has_data selects the SRAM read port onto d_data
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] param;
    logic [2:0] size;
    logic       sink;
    logic       denied;
    logic       corrupt;
    logic       has_data;
  } d_resp_t;

endpackage

// File: rtl/tl_sram_array.sv
// 1RW synchronous SRAM with byte-lane write mask; the read register
// only loads on a read access so it holds while D is stalled.
module tl_sram_array #(
  parameter int DEPTH  = 2048,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   wmask,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tl_sram_slave.sv
// TileLink-UL manager terminating the A/D link onto a byte-masked SRAM,
// one access per cycle with a single registered D response slot.
module tl_sram_slave
  import tl_pkg::*;
#(
  parameter int                ADDR_W    = 21,
  parameter int                DATA_W    = 64,
  parameter int                SRC_W     = 5,
  parameter int                DEPTH     = 2048,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 21'h10000
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [2:0]          auto_in_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [2:0]          auto_in_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_d_bits_source,
  output logic                auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WIN_I = DEPTH * 8;

  logic              a_fire;
  logic              d_fire;
  logic [ADDR_W:0]   win;
  logic [ADDR_W:0]   off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              is_put;
  logic              is_get;
  logic              data_op;
  logic              legal;
  logic              sram_en;
  logic [DATA_W-1:0] sram_rdata;
  d_resp_t           resp_n;

  logic              d_valid_q, d_valid_d;
  d_resp_t           d_resp_q, d_resp_d;
  logic [SRC_W-1:0]  d_src_q, d_src_d;

  // window end in ADDR_W+1 bits so BASE+size cannot wrap
  assign win = WIN_I[ADDR_W:0];
  assign off = {1'b0, auto_in_a_bits_address} - {1'b0, BASE_ADDR};
  assign idx = off[IDX_W+2:3];

  always_comb begin
    in_range = (auto_in_a_bits_address >= BASE_ADDR) && (off < win);
    is_put   = (auto_in_a_bits_opcode == A_PUT_FULL) ||
               (auto_in_a_bits_opcode == A_PUT_PARTIAL);
    is_get   = (auto_in_a_bits_opcode == A_GET);
    data_op  = (auto_in_a_bits_opcode == A_ARITH) ||
               (auto_in_a_bits_opcode == A_LOGIC) || is_get;
    legal    = in_range && (auto_in_a_bits_size <= 3'd3) &&
               (is_put || is_get) &&
               !(is_put && auto_in_a_bits_corrupt);

    resp_n.opcode   = data_op ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
    resp_n.param    = 2'd0;
    resp_n.size     = auto_in_a_bits_size;
    resp_n.sink     = 1'b0;
    resp_n.denied   = !legal;
    resp_n.corrupt  = !legal && data_op;
    resp_n.has_data = legal && is_get;
  end

  assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
  assign a_fire  = auto_in_a_valid && auto_in_a_ready;
  assign d_fire  = d_valid_q && auto_in_d_ready;
  assign sram_en = a_fire && legal;

  tl_sram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .en    (sram_en),
    .we    (is_put),
    .addr  (idx),
    .wmask (auto_in_a_bits_mask),
    .wdata (auto_in_a_bits_data),
    .rdata (sram_rdata)
  );

  always_comb begin
    d_valid_d = d_valid_q;
    d_resp_d  = d_resp_q;
    d_src_d   = d_src_q;
    if (a_fire) begin
      d_valid_d = 1'b1;
      d_resp_d  = resp_n;
      d_src_d   = auto_in_a_bits_source;
    end else if (d_fire) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid_q <= 1'b0;
      d_resp_q  <= '0;
      d_src_q   <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_resp_q  <= d_resp_d;
      d_src_q   <= d_src_d;
    end
  end

  assign auto_in_d_valid        = d_valid_q;
  assign auto_in_d_bits_opcode  = d_resp_q.opcode;
  assign auto_in_d_bits_param   = d_resp_q.param;
  assign auto_in_d_bits_size    = d_resp_q.size;
  assign auto_in_d_bits_source  = d_src_q;
  assign auto_in_d_bits_sink    = d_resp_q.sink;
  assign auto_in_d_bits_denied  = d_resp_q.denied;
  assign auto_in_d_bits_corrupt = d_resp_q.corrupt;
  assign auto_in_d_bits_data    = d_resp_q.has_data ? sram_rdata : '0;

  logic unused_ok;
  assign unused_ok = ^{auto_in_a_bits_param, off[ADDR_W:IDX_W+3], off[2:0]};

endmodule
